vga_ellipse_ctrl: RTL and testbench
===================================

VGA_ELLIPSE_CTRL -- requirements
Module: vga_ellipse_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 2, meaning frames per animation step (1..15).
REQ-002 SHALL have parameter DEF_A, default 200, meaning the reset x semi-axis in pixels.
REQ-003 SHALL have parameter DEF_B, default 100, meaning the reset y semi-axis in pixels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports pix_x and pix_y, input, 10 bits each: the current pixel coordinate, where 10'h3ff means not active.
REQ-007 SHALL have port enable, input, 1 bit: the animation run request.
REQ-008 SHALL have port cfg_valid, input, 1 bit, and port cfg_ready, output, 1 bit: the config handshake.
REQ-009 SHALL have ports cfg_dx and cfg_dy, input, 4 bits signed each: the step per update.
REQ-010 SHALL have ports cfg_a, input, 9 bits, and cfg_b, input, 9 bits: the requested semi-axes.
REQ-011 SHALL have ports ctr_x and ctr_y, output, 10 bits each: the ellipse centre driven to the image generator.
REQ-012 SHALL have ports rad_a and rad_b, output, 9 bits each: the semi-axes driven to the image generator.
REQ-013 SHALL have port param_upd, output, 1 bit: a one-cycle pulse when the outputs change.

Function
REQ-014 SHALL detect a frame tick when pix_x==639 and pix_y==479, registered as one pulse per frame.
REQ-015 SHALL implement the FSM states IDLE, RUN, STEP and COMMIT.
- IDLE->RUN when enable=1.
- RUN->STEP on a frame tick once the divider reaches FRAME_DIV-1; otherwise the divider increments on each tick.
- STEP->COMMIT unconditionally.
- COMMIT->RUN, or COMMIT->IDLE if enable=0.
REQ-016 SHALL drop enable only in RUN, with the transition to IDLE on the next cycle; the outputs hold their values.
REQ-017 SHALL assert cfg_ready in IDLE and RUN only; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-018 SHALL capture an accepted config into a shadow register and apply it in the next COMMIT; a later accept before that COMMIT overwrites the shadow.
REQ-019 SHALL apply a config accepted in the same cycle as the triggering frame tick in that step's COMMIT.
REQ-020 SHALL clamp the shadow semi-axes to rad_a in 1..319 and rad_b in 1..239 at capture.
REQ-021 SHALL compute in STEP nx=ctr_x+dx and ny=ctr_y+dy using 11-bit signed arithmetic.
REQ-022 SHALL handle the x edges as follows.
- If nx-a<0: nx=a and dx is negated.
- If nx+a>639: nx=639-a and dx is negated.
- y SHALL be handled the same way, with limit 479 and semi-axis b.
REQ-023 SHALL clamp the centre after a config is applied so the ellipse lies fully on screen, using the same rule as REQ-022 with no direction flip.
REQ-024 SHALL update ctr_x, ctr_y, rad_a and rad_b only in COMMIT and assert param_upd for exactly that cycle.
- Latency from frame tick to param_upd is 2 cycles.
- Outputs are stable for the whole active frame.
REQ-025 SHALL make dx=0 and dy=0 legal, giving a static centre while param_upd still pulses.

Reset
REQ-026 SHALL set, on rst=1 (asynchronous, any state, including mid-STEP/COMMIT), the following values.
- state=IDLE, divider=0.
- ctr_x=320, ctr_y=240.
- rad_a=DEF_A, rad_b=DEF_B.
- dx=+1, dy=+1.
- param_upd=0, cfg_ready=0 in the reset cycle.
- Shadow register empty.
REQ-027 SHALL discard any config pending at reset.

Configuration
REQ-028 SHALL, with ELLIPSE_BREATHE_EN defined, change rad_a and rad_b by 1 each COMMIT between half the configured value and the full configured value, reversing direction at each limit, with the centre clamp re-applied.
REQ-029 SHALL, without ELLIPSE_BREATHE_EN, keep the radii constant except on config apply; no breathe logic is present.

Structure
REQ-030 SHALL place H_ACT=640, V_ACT=480, the FSM state encoding, and the centre and axis limit constants in package vga_ell_pkg.
REQ-031 SHALL implement the frame-tick detector and FRAME_DIV divider as sub-module ell_frame_tick, with outputs tick and step_due.

Verification
REQ-032 SHALL cover reset behaviour: after rst release, ctr=(320,240), rad=(200,100), param_upd=0, and cfg_ready=0 until enable=1, then 1.
REQ-033 SHALL cover the step rate: with enable=1, FRAME_DIV=2, dx=dy=+1, the outputs are (321,241) two frame ticks after start, with param_upd two cycles after the tick.
REQ-034 SHALL cover the right bounce: cfg dx=+7, a=200 with ctr_x=436 gives nx=443>439, so ctr_x=439 and the next step gives 432.
REQ-035 SHALL cover config clamping: cfg_a=400 and cfg_b=300 apply as rad=(319,239) with the centre forced to (320,240).
REQ-036 SHALL cover the simultaneous case: a cfg accepted on the tick cycle applies in that COMMIT, and rst asserted in STEP returns all reset values the same cycle.
REQ-037 SHALL cover breathe mode: with ELLIPSE_BREATHE_EN and a=200, rad_a runs 199, 198 … 100, 101 …

Source files
------------

// File: rtl/vga_ell_pkg.sv
// Shared constants, FSM encoding and edge-fit helpers for the VGA ellipse controller.
package vga_ell_pkg;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    localparam logic [9:0] X_MAX     = 10'(H_ACT - 1);
    localparam logic [9:0] Y_MAX     = 10'(V_ACT - 1);
    localparam logic [9:0] CTR_X_RST = 10'(H_ACT / 2);
    localparam logic [9:0] CTR_Y_RST = 10'(V_ACT / 2);
    localparam logic [8:0] A_MAX     = 9'(H_ACT / 2 - 1);
    localparam logic [8:0] B_MAX     = 9'(V_ACT / 2 - 1);
    localparam logic [8:0] AXIS_MIN  = 9'd1;

    typedef enum logic [1:0] {IDLE, RUN, STEP, COMMIT} state_t;

    // Semi-axis limited to AXIS_MIN..max so the ellipse is never degenerate or wider than the screen.
    function automatic logic [8:0] clamp_axis(input logic [8:0] r, input logic [8:0] max);
        if (r < AXIS_MIN) return AXIS_MIN;
        if (r > max)      return max;
        return r;
    endfunction

    // Centre position that keeps [p-r, p+r] inside 0..lim.
    function automatic logic [9:0] fit_pos(input logic signed [10:0] p, input logic [8:0] r,
                                           input logic [9:0] lim);
        logic signed [10:0] rs;
        rs = $signed({2'b00, r});
        if (p - rs < 11'sd0)             return {1'b0, r};
        if (p + rs > $signed({1'b0, lim})) return lim - {1'b0, r};
        return p[9:0];
    endfunction

    // True when fit_pos had to move the centre (an edge was hit).
    function automatic logic fit_hit(input logic signed [10:0] p, input logic [8:0] r,
                                     input logic [9:0] lim);
        logic signed [10:0] rs;
        rs = $signed({2'b00, r});
        return (p - rs < 11'sd0) || (p + rs > $signed({1'b0, lim}));
    endfunction

endpackage

// File: rtl/ell_frame_tick.sv
// Frame tick detector (one pulse per frame at the last active pixel) and FRAME_DIV step divider.
module ell_frame_tick
    import vga_ell_pkg::*;
#(
    parameter int FRAME_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       run,
    output logic       tick,
    output logic       step_due
);

    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

    logic       hit;
    logic       hit_d;
    logic [3:0] div;

    assign hit      = (pix_x == X_MAX) && (pix_y == Y_MAX);
    assign step_due = tick && (div == DIV_LAST);

    // Rising edge of the last-pixel match, so a held coordinate still gives one tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_d <= 1'b0;
            tick  <= 1'b0;
        end else begin
            hit_d <= hit;
            tick  <= hit && !hit_d;
        end
    end

    // Frame divider: counts ticks while running, restarts from zero whenever not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (!run)
            div <= '0;
        else if (tick)
            div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    end

endmodule

// File: rtl/vga_ellipse_ctrl.sv
// Bouncing-ellipse parameter controller for a 640x480 image generator.
// Optional feature: define ELLIPSE_BREATHE_EN to make the semi-axes oscillate between
// half and full of their configured size, one pixel per step.
module vga_ellipse_ctrl
    import vga_ell_pkg::*;
#(
    parameter int FRAME_DIV = 2,
    parameter int DEF_A     = 200,
    parameter int DEF_B     = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic signed [3:0] cfg_dx,
    input  logic signed [3:0] cfg_dy,
    input  logic [8:0]        cfg_a,
    input  logic [8:0]        cfg_b,
    output logic [9:0]        ctr_x,
    output logic [9:0]        ctr_y,
    output logic [8:0]        rad_a,
    output logic [8:0]        rad_b,
    output logic              param_upd
);

    state_t            state;
    logic              tick, step_due, xfer;
    // Direction is kept 5 bits wide so that negating a step of -8 stays exact.
    logic signed [4:0] dx, dy, sdx, sdy, ndx, ndy;
    logic              sh_vld;
    logic [8:0]        sh_a, sh_b, na, nb;
    logic signed [3:0] sh_dx, sh_dy;
    logic [9:0]        px, py, nx, ny;
    logic signed [10:0] sx, sy;
`ifdef ELLIPSE_BREATHE_EN
    logic [8:0]        full_a, full_b, nfa, nfb;
    logic              shr_a, shr_b, nsa, nsb;

    // One breathe step: returns {shrinking, next radius} between max(full/2,1) and full.
    function automatic logic [9:0] breathe(input logic [8:0] r, input logic [8:0] full,
                                           input logic shrink);
        logic [8:0] lo;
        lo = ((full >> 1) == 9'd0) ? 9'd1 : (full >> 1);
        if (shrink) begin
            if (r > lo)        return {1'b1, r - 9'd1};
            else if (r < full) return {1'b0, r + 9'd1};
            else               return {1'b1, r};
        end else begin
            if (r < full)      return {1'b0, r + 9'd1};
            else if (r > lo)   return {1'b1, r - 9'd1};
            else               return {1'b0, r};
        end
    endfunction
`endif

    ell_frame_tick #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .run      (state == RUN),
        .tick     (tick),
        .step_due (step_due)
    );

    // Config is accepted while idle-with-enable or running; never while a step is in flight.
    assign cfg_ready = !rst && ((state == RUN) || (state == IDLE && enable));
    assign xfer      = cfg_valid && cfg_ready;

    // Shadow config: latest accepted request wins, consumed by the step that follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_vld <= 1'b0;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_dx  <= '0;
            sh_dy  <= '0;
        end else if (xfer) begin
            sh_vld <= 1'b1;
            sh_a   <= clamp_axis(cfg_a, A_MAX);
            sh_b   <= clamp_axis(cfg_b, B_MAX);
            sh_dx  <= cfg_dx;
            sh_dy  <= cfg_dy;
        end else if (state == STEP) begin
            sh_vld <= 1'b0;
        end
    end

    // Next parameters: apply shadow (or breathe), re-fit centre without flip, then move and bounce.
    always_comb begin
        na  = rad_a;
        nb  = rad_b;
        sdx = dx;
        sdy = dy;
`ifdef ELLIPSE_BREATHE_EN
        nfa = full_a;
        nfb = full_b;
        nsa = shr_a;
        nsb = shr_b;
`endif
        if (sh_vld) begin
            na  = sh_a;
            nb  = sh_b;
            sdx = {sh_dx[3], sh_dx};
            sdy = {sh_dy[3], sh_dy};
`ifdef ELLIPSE_BREATHE_EN
            nfa = sh_a;
            nfb = sh_b;
            nsa = 1'b1;
            nsb = 1'b1;
`endif
        end
`ifdef ELLIPSE_BREATHE_EN
        else begin
            {nsa, na} = breathe(rad_a, full_a, shr_a);
            {nsb, nb} = breathe(rad_b, full_b, shr_b);
        end
`endif
        px  = fit_pos($signed({1'b0, ctr_x}), na, X_MAX);
        py  = fit_pos($signed({1'b0, ctr_y}), nb, Y_MAX);
        sx  = $signed({1'b0, px}) + $signed({{6{sdx[4]}}, sdx});
        sy  = $signed({1'b0, py}) + $signed({{6{sdy[4]}}, sdy});
        nx  = fit_pos(sx, na, X_MAX);
        ny  = fit_pos(sy, nb, Y_MAX);
        ndx = fit_hit(sx, na, X_MAX) ? -sdx : sdx;
        ndy = fit_hit(sy, nb, Y_MAX) ? -sdy : sdy;
    end

    // Control FSM; outputs change only on entry to COMMIT, flagged by param_upd for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctr_x     <= CTR_X_RST;
            ctr_y     <= CTR_Y_RST;
            rad_a     <= 9'(DEF_A);
            rad_b     <= 9'(DEF_B);
            dx        <= 5'sd1;
            dy        <= 5'sd1;
            param_upd <= 1'b0;
`ifdef ELLIPSE_BREATHE_EN
            full_a    <= 9'(DEF_A);
            full_b    <= 9'(DEF_B);
            shr_a     <= 1'b1;
            shr_b     <= 1'b1;
`endif
        end else begin
            param_upd <= 1'b0;
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN: begin
                    if (!enable)                 state <= IDLE;
                    else if (tick && step_due)   state <= STEP;
                end
                STEP: begin
                    state     <= COMMIT;
                    ctr_x     <= nx;
                    ctr_y     <= ny;
                    rad_a     <= na;
                    rad_b     <= nb;
                    dx        <= ndx;
                    dy        <= ndy;
                    param_upd <= 1'b1;
`ifdef ELLIPSE_BREATHE_EN
                    full_a    <= nfa;
                    full_b    <= nfb;
                    shr_a     <= nsa;
                    shr_b     <= nsb;
`endif
                end
                COMMIT:  state <= enable ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ellipse_ctrl.sv
// Directed bench for vga_ellipse_ctrl (default parameters, FRAME_DIV=2).
module tb_vga_ellipse_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        pix_x, pix_y;
    logic              enable, cfg_valid, cfg_ready;
    logic signed [3:0] cfg_dx, cfg_dy;
    logic [8:0]        cfg_a, cfg_b;
    logic [9:0]        ctr_x, ctr_y;
    logic [8:0]        rad_a, rad_b;
    logic              param_upd;

    int checks = 0;
    int errors = 0;

    vga_ellipse_ctrl dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .ctr_x(ctr_x), .ctr_y(ctr_y),
        .rad_a(rad_a), .rad_b(rad_b), .param_upd(param_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cv;
        int a, b, dx, dy;
        int n;
        int ex, ey, ea, eb;
    } vec_t;

    vec_t vt[14];

    function automatic logic [37:0] pk(input int x, input int y, input int a, input int b);
        return {10'(x), 10'(y), 9'(a), 9'(b)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int x, input int y, input int a, input int b);
        chk(nm, {26'd0, ctr_x, ctr_y, rad_a, rad_b}, {26'd0, pk(x, y, a, b)});
    endtask

    task automatic set_cfg(input int a, input int b, input int dx, input int dy);
        cfg_a  = 9'(a);
        cfg_b  = 9'(b);
        cfg_dx = 4'(dx);
        cfg_dy = 4'(dy);
    endtask

    task automatic send_cfg(input int a, input int b, input int dx, input int dy);
        set_cfg(a, b, dx, dy);
        cfg_valid = 1'b1;
        chk("cfg_ready_send", 64'(cfg_ready), 64'd1);
        cyc();
        cfg_valid = 1'b0;
    endtask

    // One frame: last active pixel for one cycle, then watch 6 cycles.
    // mode 1: present a config on the tick cycle; mode 2: assert reset in STEP.
    task automatic frame(input int mode, output int lat, output int np);
        pix_x = 10'd639;
        pix_y = 10'd479;
        cyc();
        pix_x = 10'h3ff;
        pix_y = 10'h3ff;
        lat = -1;
        np  = 0;
        for (int i = 1; i <= 6; i++) begin
            if (param_upd) begin
                np++;
                if (lat < 0) lat = i;
            end
            cfg_valid = (mode == 1 && i == 1);
            if (mode == 1 && i == 1) chk("cfg_ready_tick", 64'(cfg_ready), 64'd1);
            if (mode == 2 && i == 2) begin
                rst = 1'b1;
                #1;
                chk_out("rst_step_out", 320, 240, 200, 100);
                chk("rst_step_upd", 64'(param_upd), 64'd0);
                chk("rst_step_ready", 64'(cfg_ready), 64'd0);
            end
            if (mode == 2 && i == 3) rst = 1'b0;
            cyc();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic run_steps(input int n, output int lat, output int pulses);
        int l, p;
        pulses = 0;
        lat    = -1;
        for (int k = 0; k < n; k++) begin
            for (int f = 0; f < 2; f++) begin
                frame(0, l, p);
                pulses += p;
                lat = l;
            end
        end
    endtask

    initial begin
        int lat, np;

        // after (321,241): dx=dy=+1, a=200, b=100
        vt[0]  = '{0,   0,   0,  0,  0,  1, 322, 242, 200, 100};
        vt[1]  = '{1, 200, 100,  2,  0,  1, 324, 242, 200, 100};
        vt[2]  = '{1, 200, 100,  7,  0, 16, 436, 242, 200, 100};
        vt[3]  = '{0,   0,   0,  0,  0,  1, 439, 242, 200, 100};
        vt[4]  = '{0,   0,   0,  0,  0,  1, 432, 242, 200, 100};
        vt[5]  = '{1, 200, 100,  0, -7,  1, 432, 235, 200, 100};
        vt[6]  = '{0,   0,   0,  0,  0, 19, 432, 102, 200, 100};
        vt[7]  = '{0,   0,   0,  0,  0,  1, 432, 100, 200, 100};
        vt[8]  = '{0,   0,   0,  0,  0,  1, 432, 107, 200, 100};
        vt[9]  = '{1, 400, 300,  1,  1,  1, 320, 240, 319, 239};
        vt[10] = '{0,   0,   0,  0,  0,  1, 319, 240, 319, 239};
        vt[11] = '{1,   0,   0,  0,  0,  1, 319, 240,   1,   1};
        vt[12] = '{0,   0,   0,  0,  0,  1, 319, 240,   1,   1};
        vt[13] = '{1,   5,   5, -8, -8,  1, 311, 232,   5,   5};

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        pix_x = 10'h3ff; pix_y = 10'h3ff;
        set_cfg(0, 0, 0, 0);
        cyc();
        cyc();
        chk_out("reset_out", 320, 240, 200, 100);
        chk("reset_upd", 64'(param_upd), 64'd0);
        chk("reset_ready", 64'(cfg_ready), 64'd0);
        rst = 1'b0;
        cyc();
        cyc();
        chk("idle_ready", 64'(cfg_ready), 64'd0);
        chk("idle_upd", 64'(param_upd), 64'd0);
        enable = 1'b1;
        cyc();
        chk("run_ready", 64'(cfg_ready), 64'd1);

`ifdef ELLIPSE_BREATHE_EN
        for (int k = 1; k <= 3; k++) begin
            run_steps(1, lat, np);
            chk($sformatf("breathe%0d_out", k), {26'd0, ctr_x, ctr_y, rad_a, rad_b},
                {26'd0, pk(320 + k, 240 + k, 200 - k, 100 - k)});
            chk($sformatf("breathe%0d_lat", k), 64'(lat), 64'd3);
        end
`else
        frame(0, lat, np);
        chk("first_frame_pulses", 64'(np), 64'd0);
        frame(0, lat, np);
        chk("step_latency", 64'(lat), 64'd3);
        chk("step_pulses", 64'(np), 64'd1);
        chk_out("step_out", 321, 241, 200, 100);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].cv) send_cfg(vt[i].a, vt[i].b, vt[i].dx, vt[i].dy);
            run_steps(vt[i].n, lat, np);
            chk_out($sformatf("vec%0d_out", i), vt[i].ex, vt[i].ey, vt[i].ea, vt[i].eb);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_pulses", i), 64'(np), 64'(vt[i].n));
        end

        // Second accept before the step overwrites the first.
        send_cfg(50, 50, 3, 3);
        send_cfg(60, 70, 1, -1);
        run_steps(1, lat, np);
        chk_out("overwrite_out", 312, 231, 60, 70);

        // Config accepted on the tick cycle lands in that step.
        frame(0, lat, np);
        chk("pre_tick_pulses", 64'(np), 64'd0);
        set_cfg(100, 100, 2, 2);
        frame(1, lat, np);
        chk_out("tick_cfg_out", 314, 233, 100, 100);
        chk("tick_cfg_lat", 64'(lat), 64'd3);

        // Dropping enable: idle, no ready, outputs hold through frames.
        enable = 1'b0;
        cyc();
        chk("disable_ready", 64'(cfg_ready), 64'd0);
        frame(0, lat, np);
        frame(0, lat, np);
        chk("disable_pulses", 64'(np), 64'd0);
        chk_out("disable_hold", 314, 233, 100, 100);
        enable = 1'b1;
        cyc();

        // Reset in STEP with a pending config: everything returns to defaults, config dropped.
        send_cfg(300, 200, 5, 5);
        frame(0, lat, np);
        frame(2, lat, np);
        chk("rst_step_pulses", 64'(np), 64'd0);
        run_steps(1, lat, np);
        chk_out("post_rst_out", 321, 241, 200, 100);
        chk("post_rst_lat", 64'(lat), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
